fastram_autoconfig: RTL and testbench

//  Zorro II autoconfig responder and local fast-RAM decoder feeding the Amiga bus stage.

---
 rtl/fastram_autoconfig_pkg.sv | 37 +++
 rtl/fastram_autoconfig_rom.sv | 40 ++++
 rtl/fastram_autoconfig.sv | 138 +++++++++++++
 tb/tb_fastram_autoconfig.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fastram_autoconfig_pkg.sv
// Shared definitions for the Zorro II fast-RAM autoconfig responder:
// state encodings, config register byte offsets and the size-to-mask table.
package fastram_autoconfig_pkg;

    typedef enum logic [1:0] {
        CFG_UNCONF     = 2'd0,
        CFG_CONFIGURED = 2'd1,
        CFG_SHUTUP     = 2'd2
    } cfg_state_e;

    typedef enum logic [1:0] {
        CYC_IDLE = 2'd0,
        CYC_WAIT = 2'd1,
        CYC_ACKD = 2'd2
    } cyc_state_e;

    localparam logic [7:0] CFG_SPACE_HI = 8'hE8;
    localparam logic [2:0] FC_CPU_SPACE = 3'b111;

    localparam logic [6:0] OFS_TYPE    = 7'h00;
    localparam logic [6:0] OFS_SIZE    = 7'h02;
    localparam logic [6:0] OFS_PROD_HI = 7'h04;
    localparam logic [6:0] OFS_PROD_LO = 7'h06;
    localparam logic [6:0] OFS_BASE    = 7'h4A;
    localparam logic [6:0] OFS_SHUTUP  = 7'h4C;

    // Which of A[23:20] take part in the window compare for each er_Type size code.
    function automatic logic [3:0] size_mask(input logic [2:0] code);
        case (code)
            3'b111:  return 4'b1100;
            3'b110:  return 4'b1110;
            3'b101:  return 4'b1111;
            default: return 4'b1000;
        endcase
    endfunction

endpackage

// File: rtl/fastram_autoconfig_rom.sv
// Combinational autoconfig register file: returns the nibble presented on
// D[31:28] for a given config-space byte offset.
module fastram_autoconfig_rom
    import fastram_autoconfig_pkg::*;
#(
    parameter logic [2:0]  SIZE_CODE  = 3'b000,
    parameter logic [7:0]  PRODUCT_ID = 8'h0A,
    parameter logic [15:0] MANUF_ID   = 16'h082C,
    parameter logic [31:0] SERIAL     = 32'h0
) (
    input  logic [6:0] ofs_i,
    output logic [3:0] nibble_o
);

    // Only $00 and $02 are presented true; every other field is ones-complemented.
    always_comb begin
        // NOTE: default first so every path assigns nibble_o and no latch is inferred.
        nibble_o = 4'hF;
        case (ofs_i)
            OFS_TYPE:    nibble_o = 4'b1110;
            OFS_SIZE:    nibble_o = {1'b0, SIZE_CODE};
            OFS_PROD_HI: nibble_o = ~PRODUCT_ID[7:4];
            OFS_PROD_LO: nibble_o = ~PRODUCT_ID[3:0];
            7'h10:       nibble_o = ~MANUF_ID[15:12];
            7'h12:       nibble_o = ~MANUF_ID[11:8];
            7'h14:       nibble_o = ~MANUF_ID[7:4];
            7'h16:       nibble_o = ~MANUF_ID[3:0];
            7'h18:       nibble_o = ~SERIAL[31:28];
            7'h1A:       nibble_o = ~SERIAL[27:24];
            7'h1C:       nibble_o = ~SERIAL[23:20];
            7'h1E:       nibble_o = ~SERIAL[19:16];
            7'h20:       nibble_o = ~SERIAL[15:12];
            7'h22:       nibble_o = ~SERIAL[11:8];
            7'h24:       nibble_o = ~SERIAL[7:4];
            7'h26:       nibble_o = ~SERIAL[3:0];
            default:     nibble_o = 4'hF;
        endcase
    end

endmodule

// File: rtl/fastram_autoconfig.sv
// Zorro II autoconfig responder and fast-RAM window decoder: classifies each
// 68030 cycle as internal or external and generates INTCYCLE, RAMCS and ACK.
module fastram_autoconfig
    import fastram_autoconfig_pkg::*;
#(
    parameter logic [2:0]  SIZE_CODE   = 3'b000,
    parameter logic [7:0]  PRODUCT_ID  = 8'h0A,
    parameter logic [15:0] MANUF_ID    = 16'h082C,
    parameter logic [31:0] SERIAL      = 32'h0,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        CLKCPU,
    input  logic        RESET,
    input  logic [23:1] A,
    input  logic [2:0]  FC,
    input  logic        AS20,
    input  logic        DS20,
    input  logic        RW20,
    input  logic [3:0]  D_IN,
    output logic [3:0]  D_OUT,
    output logic        D_OE,
    output logic        INTCYCLE,
    output logic        RAMCS,
    output logic        ACK,
    output logic        CONFIGURED
);

    cfg_state_e cfg_state_q, cfg_state_d;
    logic [3:0] base_q, base_d;

    cyc_state_e cyc_q, cyc_d;
    logic [2:0] cnt_q, cnt_d;
    logic       is_cfg_q, is_cfg_d;
    logic       is_ram_q, is_ram_d;

    logic       cfg_hit, ram_hit, ack_edge, cfg_write, cyc_clr;
    logic [6:0] reg_ofs;
    logic [3:0] rom_nibble;
    logic       unused_addr;

    assign unused_addr = ^A[15:7];
    assign reg_ofs     = {A[6:1], 1'b0};

    assign cfg_hit = (cfg_state_q == CFG_UNCONF) && (A[23:16] == CFG_SPACE_HI)
                  && (FC != FC_CPU_SPACE);
    assign ram_hit = (cfg_state_q == CFG_CONFIGURED)
                  && (((A[23:20] ^ base_q) & size_mask(SIZE_CODE)) == 4'h0)
                  && (FC != FC_CPU_SPACE);

    assign ack_edge  = (cyc_q == CYC_WAIT) && (cnt_q == 3'(WAIT_STATES));
    assign cfg_write = ack_edge && is_cfg_q && !RW20 && !DS20;

    // Config state only moves on an acknowledged, strobed write while unconfigured.
    always_comb begin
        cfg_state_d = cfg_state_q;
        base_d      = base_q;
        if (cfg_write && cfg_state_q == CFG_UNCONF) begin
            case (reg_ofs)
                OFS_BASE: begin
                    cfg_state_d = CFG_CONFIGURED;
                    base_d      = D_IN;
                end
                OFS_SHUTUP: cfg_state_d = CFG_SHUTUP;
                default:    cfg_state_d = cfg_state_q;
            endcase
        end
    end

    always_ff @(posedge CLKCPU or posedge RESET) begin
        if (RESET) begin
            cfg_state_q <= CFG_UNCONF;
            base_q      <= 4'h0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            cfg_state_q <= cfg_state_d;
            base_q      <= base_d;
        end
    end

    always_comb begin
        cyc_d    = cyc_q;
        cnt_d    = cnt_q;
        is_cfg_d = is_cfg_q;
        is_ram_d = is_ram_q;
        case (cyc_q)
            CYC_IDLE: begin
                if (!AS20 && (cfg_hit || ram_hit)) begin
                    cyc_d    = CYC_WAIT;
                    cnt_d    = 3'd0;
                    is_cfg_d = cfg_hit;
                    is_ram_d = ram_hit;
                end
            end
            CYC_WAIT: begin
                if (ack_edge) cyc_d = CYC_ACKD;
                else          cnt_d = cnt_q + 3'd1;
            end
            CYC_ACKD: cyc_d = CYC_ACKD;
            default:  cyc_d = CYC_IDLE;
        endcase
    end

    // NOTE: AS20 negation is an asynchronous clear of the cycle FSM, so the
    // strobes release in the same bus cycle rather than at the next clock.
    assign cyc_clr = RESET | AS20;

    always_ff @(posedge CLKCPU or posedge cyc_clr) begin
        if (cyc_clr) begin
            cyc_q    <= CYC_IDLE;
            cnt_q    <= 3'd0;
            is_cfg_q <= 1'b0;
            is_ram_q <= 1'b0;
        end else begin
            cyc_q    <= cyc_d;
            cnt_q    <= cnt_d;
            is_cfg_q <= is_cfg_d;
            is_ram_q <= is_ram_d;
        end
    end

    fastram_autoconfig_rom #(
        .SIZE_CODE  (SIZE_CODE),
        .PRODUCT_ID (PRODUCT_ID),
        .MANUF_ID   (MANUF_ID),
        .SERIAL     (SERIAL)
    ) u_rom (
        .ofs_i    (reg_ofs),
        .nibble_o (rom_nibble)
    );

    assign INTCYCLE   = (cyc_q == CYC_IDLE);
    assign RAMCS      = !((cyc_q != CYC_IDLE) && is_ram_q);
    assign ACK        = (cyc_q != CYC_ACKD);
    assign D_OE       = (cyc_q == CYC_ACKD) && is_cfg_q && RW20;
    assign D_OUT      = D_OE ? rom_nibble : 4'hF;
    assign CONFIGURED = (cfg_state_q == CFG_CONFIGURED);

endmodule

// File: tb/tb_fastram_autoconfig.sv
// Directed bench for fastram_autoconfig: expected acknowledge data is queued
// when each internal cycle is launched and compared once ACK is observed.
module tb_fastram_autoconfig;

    localparam int WS = 1;

    typedef enum {K_EXT, K_CFG, K_RAM} kind_e;
    typedef struct {
        logic [3:0] d;
        logic       oe;
        logic       ram;
    } sb_item_t;

    logic        CLKCPU = 1'b0;
    logic        RESET;
    logic [23:1] A;
    logic [2:0]  FC;
    logic        AS20, DS20, RW20;
    logic [3:0]  D_IN;
    logic [3:0]  D_OUT;
    logic        D_OE, INTCYCLE, RAMCS, ACK, CONFIGURED;

    sb_item_t sb[$];
    int checks = 0;
    int errors = 0;

    fastram_autoconfig #(
        .SIZE_CODE   (3'b000),
        .PRODUCT_ID  (8'h0A),
        .MANUF_ID    (16'h082C),
        .SERIAL      (32'h0),
        .WAIT_STATES (WS)
    ) dut (
        .CLKCPU     (CLKCPU),
        .RESET      (RESET),
        .A          (A),
        .FC         (FC),
        .AS20       (AS20),
        .DS20       (DS20),
        .RW20       (RW20),
        .D_IN       (D_IN),
        .D_OUT      (D_OUT),
        .D_OE       (D_OE),
        .INTCYCLE   (INTCYCLE),
        .RAMCS      (RAMCS),
        .ACK        (ACK),
        .CONFIGURED (CONFIGURED)
    );

    always #5 CLKCPU = ~CLKCPU;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete bus cycle; internal cycles go through the scoreboard.
    task automatic bus_cycle(input string tag, input logic [23:0] addr, input logic [2:0] fc,
                             input logic rw, input logic ds_low, input logic [3:0] din,
                             input kind_e kind, input logic [3:0] exp_d);
        sb_item_t it;
        int       n;
        logic     seen;
        @(negedge CLKCPU);
        A    = addr[23:1];
        FC   = fc;
        RW20 = rw;
        D_IN = din;
        AS20 = 1'b0;
        DS20 = !ds_low;
        if (kind != K_EXT) begin
            it.oe  = (kind == K_CFG) && rw;
            it.d   = it.oe ? exp_d : 4'hF;
            it.ram = (kind == K_RAM);
            sb.push_back(it);
        end
        @(posedge CLKCPU); #1;
        if (kind == K_EXT) begin
            seen = 1'b0;
            for (int k = 0; k < WS + 4; k++) begin
                seen = seen | !INTCYCLE | !ACK | !RAMCS | D_OE;
                @(posedge CLKCPU); #1;
            end
            check({tag, "_external"}, {31'd0, seen}, 32'd0);
        end else begin
            check({tag, "_intcycle"}, {31'd0, INTCYCLE}, 32'd0);
            n = 0;
            while (ACK !== 1'b0 && n < 16) begin
                @(posedge CLKCPU); #1;
                n++;
            end
            check({tag, "_ack_latency"}, n, WS + 1);
            it = sb.pop_front();
            check({tag, "_data"}, {28'd0, D_OUT}, {28'd0, it.d});
            check({tag, "_oe"}, {31'd0, D_OE}, {31'd0, it.oe});
            check({tag, "_ramcs"}, {31'd0, RAMCS}, {31'd0, !it.ram});
        end
        @(negedge CLKCPU);
        AS20 = 1'b1;
        DS20 = 1'b1;
        #1;
        check({tag, "_release"}, {28'd0, INTCYCLE, ACK, RAMCS, D_OE}, 32'b1110);
    endtask

    initial begin
        int n;
        RESET = 1'b1;
        A     = '0;
        FC    = 3'b101;
        AS20  = 1'b1;
        DS20  = 1'b1;
        RW20  = 1'b1;
        D_IN  = 4'h0;
        repeat (3) @(posedge CLKCPU);
        #1;
        check("reset_outputs", {28'd0, INTCYCLE, RAMCS, ACK, D_OE}, 32'b1110);
        check("reset_dout", {28'd0, D_OUT}, 32'hF);
        check("reset_configured", {31'd0, CONFIGURED}, 32'd0);
        @(negedge CLKCPU);
        RESET = 1'b0;

        bus_cycle("rd_type",   24'hE80000, 3'b101, 1'b1, 1'b1, 4'h0, K_CFG, 4'hE);
        bus_cycle("rd_size",   24'hE80002, 3'b101, 1'b1, 1'b1, 4'h0, K_CFG, 4'h0);
        bus_cycle("rd_prodhi", 24'hE80004, 3'b101, 1'b1, 1'b1, 4'h0, K_CFG, 4'hF);
        bus_cycle("rd_prodlo", 24'hE80006, 3'b110, 1'b1, 1'b1, 4'h0, K_CFG, 4'h5);
        bus_cycle("rd_manf12", 24'hE80012, 3'b101, 1'b1, 1'b1, 4'h0, K_CFG, 4'h7);
        bus_cycle("rd_manf16", 24'hE80016, 3'b101, 1'b1, 1'b1, 4'h0, K_CFG, 4'h3);
        bus_cycle("rd_unused", 24'hE80040, 3'b101, 1'b1, 1'b1, 4'h0, K_CFG, 4'hF);
        bus_cycle("cpu_space", 24'hE80000, 3'b111, 1'b1, 1'b1, 4'h0, K_EXT, 4'hF);

        // AS20 negated while still waiting: strobes must release mid-cycle.
        @(negedge CLKCPU);
        A    = 24'hE80000 >> 1;
        FC   = 3'b101;
        RW20 = 1'b1;
        AS20 = 1'b0;
        DS20 = 1'b0;
        @(posedge CLKCPU); #1;
        check("abort_in_wait", {31'd0, INTCYCLE}, 32'd0);
        #2 AS20 = 1'b1;
        DS20 = 1'b1;
        #1;
        check("abort_release", {30'd0, INTCYCLE, ACK}, 32'b11);
        bus_cycle("rd_fresh", 24'hE80002, 3'b101, 1'b1, 1'b1, 4'h0, K_CFG, 4'h0);

        bus_cycle("wr_other", 24'hE80048, 3'b101, 1'b0, 1'b1, 4'h2, K_CFG, 4'hF);
        check("wr_other_cfg", {31'd0, CONFIGURED}, 32'd0);
        bus_cycle("wr_nods",  24'hE8004A, 3'b101, 1'b0, 1'b0, 4'h2, K_CFG, 4'hF);
        check("wr_nods_cfg", {31'd0, CONFIGURED}, 32'd0);
        bus_cycle("wr_base",  24'hE8004A, 3'b101, 1'b0, 1'b1, 4'h2, K_CFG, 4'hF);
        check("configured", {31'd0, CONFIGURED}, 32'd1);

        bus_cycle("ram_rd",   24'h200000, 3'b101, 1'b1, 1'b1, 4'h0, K_RAM, 4'hF);
        bus_cycle("ram_wr",   24'h7FFFFE, 3'b001, 1'b0, 1'b1, 4'h9, K_RAM, 4'hF);
        bus_cycle("ram_miss", 24'hA00000, 3'b101, 1'b1, 1'b1, 4'h0, K_EXT, 4'hF);
        bus_cycle("cfg_gone", 24'hE80000, 3'b101, 1'b1, 1'b1, 4'h0, K_EXT, 4'hF);
        bus_cycle("ram_fc7",  24'h200000, 3'b111, 1'b1, 1'b1, 4'h0, K_EXT, 4'hF);

        // RESET pulsed while a RAM cycle sits acknowledged.
        @(negedge CLKCPU);
        A    = 24'h200000 >> 1;
        FC   = 3'b101;
        RW20 = 1'b1;
        AS20 = 1'b0;
        DS20 = 1'b0;
        n = 0;
        while (ACK !== 1'b0 && n < 16) begin
            @(posedge CLKCPU); #1;
            n++;
        end
        check("rst_ackd_reached", {31'd0, ACK}, 32'd0);
        #1 RESET = 1'b1;
        #1;
        check("rst_mid_outputs", {28'd0, INTCYCLE, RAMCS, ACK, D_OE}, 32'b1110);
        check("rst_mid_dout", {28'd0, D_OUT}, 32'hF);
        check("rst_mid_configured", {31'd0, CONFIGURED}, 32'd0);
        @(negedge CLKCPU);
        RESET = 1'b0;
        AS20  = 1'b1;
        DS20  = 1'b1;

        bus_cycle("rd_after_rst", 24'hE80000, 3'b101, 1'b1, 1'b1, 4'h0, K_CFG, 4'hE);
        bus_cycle("ram_after_rst", 24'h200000, 3'b101, 1'b1, 1'b1, 4'h0, K_EXT, 4'hF);

        bus_cycle("wr_shutup", 24'hE8004C, 3'b101, 1'b0, 1'b1, 4'h2, K_CFG, 4'hF);
        check("shutup_configured", {31'd0, CONFIGURED}, 32'd0);
        bus_cycle("shut_cfg", 24'hE80000, 3'b101, 1'b1, 1'b1, 4'h0, K_EXT, 4'hF);
        bus_cycle("shut_ram", 24'h200000, 3'b101, 1'b1, 1'b1, 4'h0, K_EXT, 4'hF);
        bus_cycle("shut_hi",  24'hA00000, 3'b101, 1'b1, 1'b1, 4'h0, K_EXT, 4'hF);
        bus_cycle("shut_base", 24'hE8004A, 3'b101, 1'b0, 1'b1, 4'h2, K_EXT, 4'hF);
        check("shutup_stays", {31'd0, CONFIGURED}, 32'd0);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
